// File: rtl/wb_dcache_nway_controller.sv
`default_nettype none
// ============================================================================
// Module   : wb_dcache_nway_controller
// Function : Control FSM for an N-way set-associative write-back data cache:
//            hit/miss handling, victim choice, write-back, refill and flush.
//            Optional perf counters enabled by defining DCACHE_PERF_CNT_EN.
// Revision : 1.0 - initial N-way release
// ============================================================================
module wb_dcache_nway_controller #(
    parameter int NUM_WAYS = 4,
    parameter int IDX_BITS = 7,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lsummu2dcache_req_i,
    input  logic                        lsummu2dcache_wr_i,
    input  logic                        dcache_kill_i,
    input  logic                        dmem_sel_i,
    input  logic                        dcache_flush_i,
    input  logic                        cache_hit_i,
    input  logic [NUM_WAYS-1:0]         hit_way_i,
    input  logic [NUM_WAYS-1:0]         way_valid_i,
    input  logic [NUM_WAYS-1:0]         way_dirty_i,
    input  logic                        mem2dcache_ack_i,
    output logic                        dcache2lsummu_ack_o,
    output logic                        cache_wr_o,
    output logic                        cache_line_wr_o,
    output logic                        cache_line_clean_o,
    output logic                        cache_wrb_req_o,
    output logic [$clog2(NUM_WAYS)-1:0] way_sel_o,
    output logic [IDX_BITS-1:0]         evict_index_o,
    output logic                        dcache2mem_req_o,
    output logic                        dcache2mem_wr_o,
    output logic                        dcache2mem_kill_o,
    output logic [CNT_W-1:0]            hit_cnt_o,
    output logic [CNT_W-1:0]            miss_cnt_o,
    output logic [CNT_W-1:0]            wb_cnt_o
);

    localparam int c_way_w = $clog2(NUM_WAYS);
    localparam logic [c_way_w-1:0] c_last_way = c_way_w'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PROCESS_REQ = 3'd1,
        S_WRITE_BACK  = 3'd2,
        S_ALLOCATE    = 3'd3,
        S_FLUSH       = 3'd4,
        S_FLUSH_NEXT  = 3'd5,
        S_FLUSH_DONE  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_req_ff;
    logic                 r_wr_ff;
    logic                 r_sel_ff;
    logic [c_way_w-1:0]   r_rr_ptr;
    logic [c_way_w-1:0]   r_victim;
    logic [IDX_BITS-1:0]  r_evict_index;
    logic [c_way_w-1:0]   r_flush_way;
    logic                 r_flush_mode;

    logic                 w_hit;
    logic                 w_kill;
    logic [c_way_w-1:0]   w_hit_way;
    logic [c_way_w-1:0]   w_victim;
    logic                 w_victim_dirty;
    logic                 w_last_entry;
    logic                 w_latch_victim;
    logic                 w_advance;
    logic                 w_clear_flush;
    logic                 w_set_flush_mode;
    logic                 w_refill_done;
    logic                 w_wb_done;

    assign w_hit        = r_req_ff & r_sel_ff & cache_hit_i;
    assign w_kill       = ~dmem_sel_i | dcache_kill_i;
    assign w_last_entry = (&r_evict_index) & (r_flush_way == c_last_way);
    assign evict_index_o = r_evict_index;

    always_comb begin
        w_hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_way_i[i]) w_hit_way = c_way_w'(i);
        end
    end

    // Descending scan so the lowest-index invalid way wins; rr_ptr otherwise.
    always_comb begin
        w_victim = r_rr_ptr;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid_i[i]) w_victim = c_way_w'(i);
        end
    end

    assign w_victim_dirty = way_valid_i[w_victim] & way_dirty_i[w_victim];

    always_comb begin
        w_next              = r_state;
        dcache2lsummu_ack_o = 1'b0;
        cache_wr_o          = 1'b0;
        cache_line_wr_o     = 1'b0;
        cache_line_clean_o  = 1'b0;
        cache_wrb_req_o     = 1'b0;
        way_sel_o           = '0;
        dcache2mem_req_o    = 1'b0;
        dcache2mem_wr_o     = 1'b0;
        dcache2mem_kill_o   = 1'b0;
        w_latch_victim      = 1'b0;
        w_advance           = 1'b0;
        w_clear_flush       = 1'b0;
        w_set_flush_mode    = 1'b0;
        w_refill_done       = 1'b0;
        w_wb_done           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (dcache_flush_i)           w_next = S_FLUSH;
                else if (lsummu2dcache_req_i) w_next = S_PROCESS_REQ;
                else                          w_clear_flush = 1'b1;
            end
            S_PROCESS_REQ: begin
                if (w_hit) begin
                    dcache2lsummu_ack_o = 1'b1;
                    cache_wr_o          = r_wr_ff;
                    way_sel_o           = w_hit_way;
                    w_next              = S_IDLE;
                end else begin
                    w_latch_victim   = 1'b1;
                    way_sel_o        = w_victim;
                    dcache2mem_req_o = 1'b1;
                    if (w_victim_dirty) begin
                        dcache2mem_wr_o = 1'b1;
                        cache_wrb_req_o = 1'b1;
                        w_next          = S_WRITE_BACK;
                    end else begin
                        w_next          = S_ALLOCATE;
                    end
                end
            end
            S_WRITE_BACK: begin
                way_sel_o = r_flush_mode ? r_flush_way : r_victim;
                if (mem2dcache_ack_i) begin
                    w_wb_done = 1'b1;
                    if (r_flush_mode) begin
                        cache_line_clean_o = 1'b1;
                        w_advance          = 1'b1;
                        w_next             = w_last_entry ? S_FLUSH_DONE : S_FLUSH_NEXT;
                    end else begin
                        dcache2mem_req_o   = 1'b1;
                        w_next             = S_ALLOCATE;
                    end
                end else begin
                    dcache2mem_req_o = 1'b1;
                    dcache2mem_wr_o  = 1'b1;
                    cache_wrb_req_o  = 1'b1;
                end
            end
            S_ALLOCATE: begin
                way_sel_o = r_victim;
                if (mem2dcache_ack_i) begin
                    cache_line_wr_o = 1'b1;
                    w_refill_done   = 1'b1;
                    w_next          = S_PROCESS_REQ;
                end else begin
                    dcache2mem_req_o = 1'b1;
                end
            end
            S_FLUSH: begin
                way_sel_o = r_flush_way;
                if (way_dirty_i[r_flush_way]) begin
                    w_set_flush_mode = 1'b1;
                    dcache2mem_req_o = 1'b1;
                    dcache2mem_wr_o  = 1'b1;
                    cache_wrb_req_o  = 1'b1;
                    w_next           = S_WRITE_BACK;
                end else begin
                    w_advance = 1'b1;
                    w_next    = w_last_entry ? S_FLUSH_DONE : S_FLUSH_NEXT;
                end
            end
            S_FLUSH_NEXT: begin
                way_sel_o = r_flush_way;
                w_next    = S_FLUSH;
            end
            S_FLUSH_DONE: begin
                dcache2lsummu_ack_o = 1'b1;
                w_clear_flush       = 1'b1;
                w_next              = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Abort wins over every transition but leaves the replacement pointer alone.
        if (w_kill) begin
            w_next            = S_IDLE;
            w_clear_flush     = 1'b1;
            cache_wr_o        = 1'b0;
            cache_line_wr_o   = 1'b0;
            dcache2mem_req_o  = 1'b0;
            dcache2mem_kill_o = 1'b1;
            w_latch_victim    = 1'b0;
            w_advance         = 1'b0;
            w_set_flush_mode  = 1'b0;
            w_refill_done     = 1'b0;
            w_wb_done         = 1'b0;
        end

        if (!rst_n) begin
            w_next              = S_IDLE;
            dcache2lsummu_ack_o = 1'b0;
            cache_wr_o          = 1'b0;
            cache_line_wr_o     = 1'b0;
            cache_line_clean_o  = 1'b0;
            cache_wrb_req_o     = 1'b0;
            way_sel_o           = '0;
            dcache2mem_req_o    = 1'b0;
            dcache2mem_wr_o     = 1'b0;
            dcache2mem_kill_o   = 1'b0;
            w_latch_victim      = 1'b0;
            w_advance           = 1'b0;
            w_clear_flush       = 1'b0;
            w_set_flush_mode    = 1'b0;
            w_refill_done       = 1'b0;
            w_wb_done           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req_ff      <= 1'b0;
            r_wr_ff       <= 1'b0;
            r_sel_ff      <= 1'b0;
            r_rr_ptr      <= '0;
            r_victim      <= '0;
            r_evict_index <= '0;
            r_flush_way   <= '0;
            r_flush_mode  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_req_ff <= lsummu2dcache_req_i;
            r_wr_ff  <= lsummu2dcache_wr_i;
            r_sel_ff <= dmem_sel_i;
            if (w_latch_victim) r_victim <= w_victim;
            if (w_refill_done)  r_rr_ptr <= r_rr_ptr + 1'b1;
            if (w_clear_flush || (r_state == S_WRITE_BACK && w_wb_done)) r_flush_mode <= 1'b0;
            else if (w_set_flush_mode)                                  r_flush_mode <= 1'b1;
            if (w_clear_flush) begin
                r_evict_index <= '0;
                r_flush_way   <= '0;
            end else if (w_advance) begin
                if (r_flush_way == c_last_way) begin
                    r_flush_way   <= '0;
                    r_evict_index <= r_evict_index + 1'b1;
                end else begin
                    r_flush_way   <= r_flush_way + 1'b1;
                end
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic             r_missed;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] r_wb_cnt;
    logic             w_hit_inc;

    // Replayed hits after a refill belong to the miss, not the hit count.
    assign w_hit_inc = (r_state == S_PROCESS_REQ) & w_hit & ~w_kill & ~r_missed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_missed   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE) r_missed <= 1'b0;
            else if (w_latch_victim) r_missed <= 1'b1;
            if (w_hit_inc && !(&r_hit_cnt))       r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (w_latch_victim && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (w_wb_done && !(&r_wb_cnt))        r_wb_cnt   <= r_wb_cnt + 1'b1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
    assign wb_cnt_o   = r_wb_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
    assign wb_cnt_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_dcache_nway_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dcache_nway_controller
// Function : Directed self-checking bench for wb_dcache_nway_controller
//            (4 ways, 2-bit index).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_dcache_nway_controller;

    localparam int NW = 4;
    localparam int IB = 2;
    localparam int CW = 32;

`ifdef DCACHE_PERF_CNT_EN
    localparam int EXP_HIT_MID = 3, EXP_MISS_MID = 2, EXP_WB_MID = 1;
    localparam int EXP_HIT_END = 3, EXP_MISS_END = 4, EXP_WB_END = 2;
`else
    localparam int EXP_HIT_MID = 0, EXP_MISS_MID = 0, EXP_WB_MID = 0;
    localparam int EXP_HIT_END = 0, EXP_MISS_END = 0, EXP_WB_END = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0, wr = 1'b0, kill = 1'b0, sel = 1'b0, flush = 1'b0;
    logic          hit = 1'b0, mem_ack = 1'b0;
    logic [NW-1:0] hit_way = '0, valid = '0, dirty = '0;
    logic          ack, cache_wr, line_wr, line_clean, wrb_req;
    logic [1:0]    way_sel;
    logic [IB-1:0] evict_index;
    logic          mem_req, mem_wr, mem_kill;
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    wb_dcache_nway_controller #(.NUM_WAYS(NW), .IDX_BITS(IB), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lsummu2dcache_req_i (req),
        .lsummu2dcache_wr_i  (wr),
        .dcache_kill_i       (kill),
        .dmem_sel_i          (sel),
        .dcache_flush_i      (flush),
        .cache_hit_i         (hit),
        .hit_way_i           (hit_way),
        .way_valid_i         (valid),
        .way_dirty_i         (dirty),
        .mem2dcache_ack_i    (mem_ack),
        .dcache2lsummu_ack_o (ack),
        .cache_wr_o          (cache_wr),
        .cache_line_wr_o     (line_wr),
        .cache_line_clean_o  (line_clean),
        .cache_wrb_req_o     (wrb_req),
        .way_sel_o           (way_sel),
        .evict_index_o       (evict_index),
        .dcache2mem_req_o    (mem_req),
        .dcache2mem_wr_o     (mem_wr),
        .dcache2mem_kill_o   (mem_kill),
        .hit_cnt_o           (hit_cnt),
        .miss_cnt_o          (miss_cnt),
        .wb_cnt_o            (wb_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic load_hit(input int way);
        @(negedge clk); req = 1'b1; wr = 1'b0; hit = 1'b0; #1;
        check("idle_no_ack", ack, 0);
        @(negedge clk); hit = 1'b1; hit_way = 4'(1 << way); #1;
        check("hit_ack", ack, 1);
        check("hit_way_sel", way_sel, way);
        check("hit_load_no_wr", cache_wr, 0);
        check("hit_no_mem_req", mem_req, 0);
        @(negedge clk); req = 1'b0; hit = 1'b0; hit_way = '0; #1;
        check("hit_ack_pulse", ack, 0);
    endtask

    initial begin
        // Reset with dmem_sel low: outputs must still be forced to zero.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ack", ack, 0);
        check("rst_mem_kill", mem_kill, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_evict_index", evict_index, 0);
        check("rst_way_sel", way_sel, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        @(negedge clk); rst_n = 1'b1; sel = 1'b1; #1;
        check("idle_no_kill", mem_kill, 0);

        // Load hit in way 2, then two more hits.
        load_hit(2);
        load_hit(0);
        load_hit(1);

        // Store miss, way 3 invalid -> allocate way 3, replay as store hit.
        @(negedge clk); req = 1'b1; wr = 1'b1; #1;
        @(negedge clk); hit = 1'b0; valid = 4'b0111; dirty = 4'b0000; #1;
        check("smiss_way_sel", way_sel, 3);
        check("smiss_mem_req", mem_req, 1);
        check("smiss_mem_wr", mem_wr, 0);
        check("smiss_no_ack", ack, 0);
        @(negedge clk); #1;
        check("alloc_hold_req", mem_req, 1);
        check("alloc_no_line_wr", line_wr, 0);
        @(negedge clk); mem_ack = 1'b1; #1;
        check("alloc_line_wr", line_wr, 1);
        check("alloc_way_sel", way_sel, 3);
        @(negedge clk); mem_ack = 1'b0; hit = 1'b1; hit_way = 4'b1000; #1;
        check("replay_ack", ack, 1);
        check("replay_store_wr", cache_wr, 1);
        check("replay_way_sel", way_sel, 3);
        @(negedge clk); req = 1'b0; wr = 1'b0; hit = 1'b0; hit_way = '0; #1;
        check("replay_ack_pulse", ack, 0);

        // All valid, rr_ptr=1, way 1 dirty -> write-back then refill of way 1.
        @(negedge clk); req = 1'b1; #1;
        @(negedge clk); valid = 4'b1111; dirty = 4'b0010; #1;
        check("dmiss_way_sel", way_sel, 1);
        check("dmiss_mem_wr", mem_wr, 1);
        check("dmiss_wrb_req", wrb_req, 1);
        @(negedge clk); #1;
        check("wb_hold_req", mem_req, 1);
        check("wb_hold_wrb", wrb_req, 1);
        check("wb_way_sel", way_sel, 1);
        @(negedge clk); mem_ack = 1'b1; #1;
        check("wb_ack_req_refill", mem_req, 1);
        check("wb_ack_wr_drop", mem_wr, 0);
        check("wb_ack_no_clean", line_clean, 0);
        @(negedge clk); mem_ack = 1'b0; #1;
        check("refill_req", mem_req, 1);
        check("refill_way_sel", way_sel, 1);
        @(negedge clk); mem_ack = 1'b1; #1;
        check("refill_line_wr", line_wr, 1);
        @(negedge clk); mem_ack = 1'b0; hit = 1'b1; hit_way = 4'b0010; #1;
        check("dreplay_ack", ack, 1);
        @(negedge clk); req = 1'b0; hit = 1'b0; hit_way = '0; #1;
        check("cnt_hit_mid", hit_cnt, EXP_HIT_MID);
        check("cnt_miss_mid", miss_cnt, EXP_MISS_MID);
        check("cnt_wb_mid", wb_cnt, EXP_WB_MID);

        // rr_ptr must now be 2: clean miss with all ways valid.
        @(negedge clk); req = 1'b1; #1;
        @(negedge clk); dirty = 4'b0000; #1;
        check("rr_victim_2", way_sel, 2);
        check("rr_clean_alloc", mem_wr, 0);
        @(negedge clk); mem_ack = 1'b1; #1;
        check("rr_line_wr", line_wr, 1);
        @(negedge clk); mem_ack = 1'b0; hit = 1'b1; hit_way = 4'b0100; #1;
        check("rr_replay_ack", ack, 1);
        @(negedge clk); req = 1'b0; hit = 1'b0; hit_way = '0; #1;

        // Full flush: only (index 1, way 3) dirty.
        @(negedge clk); flush = 1'b1; #1;
        check("flush_idle_no_ack", ack, 0);
        for (int e = 0; e < 16; e++) begin
            @(negedge clk);
            dirty = (e / 4 == 1) ? 4'b1000 : 4'b0000;
            #1;
            check("flush_index", evict_index, e / 4);
            check("flush_way", way_sel, e % 4);
            if (e == 7) begin
                @(negedge clk); #1;
                check("flush_wb_req", mem_req, 1);
                check("flush_wb_wrb", wrb_req, 1);
                check("flush_wb_way", way_sel, 3);
                @(negedge clk); mem_ack = 1'b1; #1;
                check("flush_clean", line_clean, 1);
                check("flush_clean_way", way_sel, 3);
                check("flush_clean_index", evict_index, 1);
            end else begin
                check("flush_no_clean", line_clean, 0);
            end
            @(negedge clk); mem_ack = 1'b0; dirty = 4'b0000; #1;
            if (e < 15) check("flush_bubble_no_ack", ack, 0);
            else        check("flush_done_ack", ack, 1);
        end
        @(negedge clk); flush = 1'b0; #1;
        check("flush_end_index", evict_index, 0);
        check("flush_end_ack_pulse", ack, 0);

        // Kill part-way through a flush resets the flush position.
        @(negedge clk); flush = 1'b1; #1;
        repeat (8) @(negedge clk);
        #1;
        check("kflush_index", evict_index, 1);
        @(negedge clk); kill = 1'b1; #1;
        check("kflush_mem_kill", mem_kill, 1);
        @(negedge clk); kill = 1'b0; flush = 1'b0; #1;
        check("kflush_index_clr", evict_index, 0);
        check("kflush_no_ack", ack, 0);

        // Kill during WRITE_BACK of dirty victim (rr_ptr=3).
        @(negedge clk); req = 1'b1; #1;
        @(negedge clk); valid = 4'b1111; dirty = 4'b1111; #1;
        check("kwb_victim", way_sel, 3);
        @(negedge clk); #1;
        check("kwb_req", mem_req, 1);
        @(negedge clk); kill = 1'b1; #1;
        check("kwb_mem_kill", mem_kill, 1);
        check("kwb_req_drop", mem_req, 0);
        check("kwb_no_cache_wr", cache_wr, 0);
        @(negedge clk); kill = 1'b0; req = 1'b0; dirty = 4'b0000; #1;
        check("kwb_idle_req", mem_req, 0);
        check("kwb_idle_kill", mem_kill, 0);
        check("kwb_evict_index", evict_index, 0);
        check("cnt_hit_end", hit_cnt, EXP_HIT_END);
        check("cnt_miss_end", miss_cnt, EXP_MISS_END);
        check("cnt_wb_end", wb_cnt, EXP_WB_END);

        // rr_ptr survives kill; reset during refill ack writes nothing.
        @(negedge clk); req = 1'b1; #1;
        @(negedge clk); #1;
        check("kept_rr_victim", way_sel, 3);
        @(negedge clk); rst_n = 1'b0; mem_ack = 1'b1; #1;
        check("rst_mid_line_wr", line_wr, 0);
        check("rst_mid_mem_req", mem_req, 0);
        @(negedge clk); rst_n = 1'b1; mem_ack = 1'b0; req = 1'b0; #1;
        check("rst_mid_idle_req", mem_req, 0);
        check("rst_mid_miss_cnt", miss_cnt, 0);
        @(negedge clk); req = 1'b1; #1;
        @(negedge clk); #1;
        check("rst_rr_victim", way_sel, 0);
        @(negedge clk); req = 1'b0; kill = 1'b1; #1;
        @(negedge clk); kill = 1'b0; #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
